// File: rtl/sfx_scheduler_if.sv
// ROM bus between the sound-effect scheduler (master) and the sample ROMs (slave).
`timescale 1ns/1ps
interface sfx_scheduler_if;
  logic        rom_sel;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;

  modport master (output rom_sel, output rom_addr, input rom_data);
  modport slave  (input rom_sel, input rom_addr, output rom_data);
endinterface

// File: rtl/sfx_scheduler.sv
// Plays one-shot jump/death sound effects from ROM, one sample per audio frame,
// with death taking priority over jump and re-requests restarting the effect.
`timescale 1ns/1ps
module sfx_scheduler #(
  parameter int JUMP_LEN = 4096,
  parameter int DEAD_LEN = 16384
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_jump,
  input  logic            req_dead,
  input  logic            sample_tick,
  input  logic            mute,
  sfx_scheduler_if.master rom,
  output logic [15:0]     sample_out,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, PLAY, FETCH} state_t;

  localparam logic [15:0] JUMP_LAST = 16'(JUMP_LEN - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_LEN - 1);

  state_t      state_q, state_d;
  logic        rom_sel_q, rom_sel_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [15:0] sample_q, sample_d;
  logic        done_q, done_d;
  logic        jump_prev_q, jump_prev_d;
  logic        dead_prev_q, dead_prev_d;
  logic        armed_q, armed_d;

  logic        jump_edge;
  logic        dead_edge;
  logic [15:0] last_addr;

  // Edges are masked for the first clk after reset so that a request level
  // already high at release is absorbed into the edge registers, not played.
  assign jump_edge = armed_q & req_jump & ~jump_prev_q;
  assign dead_edge = armed_q & req_dead & ~dead_prev_q;
  assign last_addr = rom_sel_q ? DEAD_LAST : JUMP_LAST;

  always_comb begin
    state_d     = state_q;
    rom_sel_d   = rom_sel_q;
    rom_addr_d  = rom_addr_q;
    sample_d    = sample_q;
    done_d      = 1'b0;
    jump_prev_d = req_jump;
    dead_prev_d = req_dead;
    armed_d     = 1'b1;

    case (state_q)
      IDLE: begin
        if (dead_edge) begin
          state_d    = PLAY;
          rom_sel_d  = 1'b1;
          rom_addr_d = 16'd0;
        end else if (jump_edge) begin
          state_d    = PLAY;
          rom_sel_d  = 1'b0;
          rom_addr_d = 16'd0;
        end else if (sample_tick) begin
          sample_d = 16'd0;
        end
      end

      PLAY, FETCH: begin
        // Preempt/restart wins over any tick or pending capture this clk.
        if (dead_edge) begin
          state_d    = PLAY;
          rom_sel_d  = 1'b1;
          rom_addr_d = 16'd0;
        end else if (jump_edge && !rom_sel_q) begin
          state_d    = PLAY;
          rom_addr_d = 16'd0;
        end else if (state_q == PLAY) begin
          if (sample_tick) begin
            state_d = FETCH;
          end
        end else begin
          sample_d = mute ? 16'd0 : rom.rom_data;
          if (rom_addr_q == last_addr) begin
            state_d    = IDLE;
            rom_addr_d = 16'd0;
            done_d     = 1'b1;
          end else begin
            state_d    = PLAY;
            rom_addr_d = rom_addr_q + 16'd1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        rom_addr_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rom_sel_q   <= 1'b0;
      rom_addr_q  <= 16'd0;
      sample_q    <= 16'd0;
      done_q      <= 1'b0;
      jump_prev_q <= 1'b0;
      dead_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_sel_q   <= rom_sel_d;
      rom_addr_q  <= rom_addr_d;
      sample_q    <= sample_d;
      done_q      <= done_d;
      jump_prev_q <= jump_prev_d;
      dead_prev_q <= dead_prev_d;
      armed_q     <= armed_d;
    end
  end

  assign rom.rom_sel  = rom_sel_q;
  assign rom.rom_addr = rom_addr_q;
  assign sample_out   = sample_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench for sfx_scheduler: directed scenarios at full effect
// lengths plus a randomized frame-level run against a behavioural model.
`timescale 1ns/1ps
module tb_sfx_scheduler;
  localparam int JUMP_LEN = 4096;
  localparam int DEAD_LEN = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_jump = 1'b0;
  logic        req_dead = 1'b0;
  logic        sample_tick = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] sample_out;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int addr_viol = 0;

  sfx_scheduler_if rom_bus();

  sfx_scheduler #(.JUMP_LEN(JUMP_LEN), .DEAD_LEN(DEAD_LEN)) dut (
    .clk(clk), .reset(reset), .req_jump(req_jump), .req_dead(req_dead),
    .sample_tick(sample_tick), .mute(mute), .rom(rom_bus),
    .sample_out(sample_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ROM contents: jump ROM holds its own address, death ROM its complement.
  function automatic logic [15:0] rom_word(input logic sel, input logic [15:0] addr);
    return sel ? ~addr : addr;
  endfunction

  always @(posedge clk) rom_bus.rom_data <= rom_word(rom_bus.rom_sel, rom_bus.rom_addr);

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rom_bus.rom_addr > (rom_bus.rom_sel ? 16'(DEAD_LEN - 1) : 16'(JUMP_LEN - 1))) addr_viol++;
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // One audio frame: tick for one clk, observe after the capture, one idle clk.
  task automatic frame(output logic [15:0] s, output logic b, output logic d);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    s = sample_out;
    b = busy;
    d = done;
    cyc();
  endtask

  task automatic do_reset();
    req_jump = 1'b0;
    req_dead = 1'b0;
    sample_tick = 1'b0;
    mute = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    checks++; if (sample_out !== 16'd0) begin errors++; $display("[TB] FAIL rst_sample: got %h want 0000", sample_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b want 0", done); end
    checks++; if (rom_bus.rom_sel !== 1'b0) begin errors++; $display("[TB] FAIL rst_sel: got %b want 0", rom_bus.rom_sel); end
    checks++; if (rom_bus.rom_addr !== 16'd0) begin errors++; $display("[TB] FAIL rst_addr: got %h want 0000", rom_bus.rom_addr); end
    reset = 1'b0;
    cyc();
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_idle: busy got %b want 0", busy); end
  endtask

  // Full jump effect with mute optionally applied over a window of frames.
  task automatic run_jump(input string name, input int mute_lo, input int mute_hi);
    logic [15:0] s, es;
    logic b, d, last;
    int bad = 0, first_k = -1, d0;
    logic [15:0] first_s = 16'd0;
    d0 = done_cnt;
    req_jump = 1'b1;
    cyc();
    checks++;
    if (busy !== 1'b1 || rom_bus.rom_sel !== 1'b0 || rom_bus.rom_addr !== 16'd0) begin
      errors++;
      $display("[TB] FAIL %s_start: busy=%b sel=%b addr=%h want 1 0 0000", name, busy, rom_bus.rom_sel, rom_bus.rom_addr);
    end
    for (int k = 0; k < JUMP_LEN; k++) begin
      mute = (k >= mute_lo && k < mute_hi);
      es = mute ? 16'd0 : rom_word(1'b0, 16'(k));
      frame(s, b, d);
      last = (k == JUMP_LEN - 1);
      if (s !== es || b !== !last || d !== last || rom_bus.rom_addr !== (last ? 16'd0 : 16'(k + 1))) begin
        if (bad == 0) begin first_k = k; first_s = s; end
        bad++;
      end
    end
    mute = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL %s_seq: %0d bad frames, first k=%0d sample=%h", name, bad, first_k, first_s); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL %s_done_count: got %0d want 1", name, done_cnt - d0); end
    frame(s, b, d);
    checks++; if (s !== 16'd0 || b !== 1'b0) begin errors++; $display("[TB] FAIL %s_tail: sample=%h busy=%b want 0000 0", name, s, b); end
    req_jump = 1'b0;
    cyc();
  endtask

  task automatic test_jump_full();
    run_jump("jump_full", 0, 0);
  endtask

  task automatic test_mute();
    run_jump("mute", 1000, 3000);
  endtask

  task automatic test_preempt();
    logic [15:0] s;
    logic b, d, last;
    int bad = 0, first_k = -1, d0;
    req_jump = 1'b1;
    cyc();
    for (int k = 0; k < 100; k++) begin
      frame(s, b, d);
      if (s !== 16'(k)) bad++;
    end
    checks++; if (bad !== 0 || rom_bus.rom_addr !== 16'd100) begin errors++; $display("[TB] FAIL preempt_lead: bad=%0d addr=%h want 0 0064", bad, rom_bus.rom_addr); end
    d0 = done_cnt;
    req_dead = 1'b1;
    cyc();
    checks++;
    if (rom_bus.rom_sel !== 1'b1 || rom_bus.rom_addr !== 16'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL preempt_switch: sel=%b addr=%h busy=%b done=%b want 1 0000 1 0", rom_bus.rom_sel, rom_bus.rom_addr, busy, done);
    end
    bad = 0;
    for (int k = 0; k < DEAD_LEN; k++) begin
      if (k == 5000) begin
        req_jump = 1'b0;
        cyc();
        req_jump = 1'b1;
        cyc();
        checks++;
        if (rom_bus.rom_sel !== 1'b1 || rom_bus.rom_addr !== 16'd5000 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL jump_ignored: sel=%b addr=%h busy=%b want 1 1388 1", rom_bus.rom_sel, rom_bus.rom_addr, busy);
        end
      end
      frame(s, b, d);
      last = (k == DEAD_LEN - 1);
      if (s !== rom_word(1'b1, 16'(k)) || b !== !last || d !== last) begin
        if (bad == 0) first_k = k;
        bad++;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL dead_seq: %0d bad frames, first k=%0d", bad, first_k); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL preempt_done_count: got %0d want 1", done_cnt - d0); end
    req_jump = 1'b0;
    req_dead = 1'b0;
    cyc();
  endtask

  task automatic test_simultaneous();
    logic [15:0] s;
    logic b, d;
    int bad = 0;
    req_jump = 1'b1;
    req_dead = 1'b1;
    cyc();
    checks++; if (rom_bus.rom_sel !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL simul_sel: sel=%b busy=%b want 1 1", rom_bus.rom_sel, busy); end
    for (int k = 0; k < 3; k++) begin
      frame(s, b, d);
      if (s !== rom_word(1'b1, 16'(k)) || rom_bus.rom_sel !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL simul_samples: %0d bad frames want 0", bad); end
    do_reset();
  endtask

  task automatic test_restart();
    logic [15:0] s;
    logic b, d;
    int bad = 0, d0;
    req_jump = 1'b1;
    cyc();
    for (int k = 0; k < 10; k++) frame(s, b, d);
    d0 = done_cnt;
    req_jump = 1'b0;
    cyc();
    req_jump = 1'b1;
    cyc();
    checks++; if (rom_bus.rom_addr !== 16'd0 || busy !== 1'b1 || rom_bus.rom_sel !== 1'b0) begin errors++; $display("[TB] FAIL restart_addr: addr=%h busy=%b sel=%b want 0000 1 0", rom_bus.rom_addr, busy, rom_bus.rom_sel); end
    for (int k = 0; k < 5; k++) begin
      frame(s, b, d);
      if (s !== 16'(k)) bad++;
    end
    checks++; if (bad !== 0 || rom_bus.rom_addr !== 16'd5) begin errors++; $display("[TB] FAIL restart_seq: bad=%0d addr=%h want 0 0005", bad, rom_bus.rom_addr); end
    // Death request lands while the jump capture is pending.
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    req_dead = 1'b1;
    cyc();
    checks++;
    if (sample_out !== 16'd4 || rom_bus.rom_sel !== 1'b1 || rom_bus.rom_addr !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fetch_preempt: sample=%h sel=%b addr=%h busy=%b want 0004 1 0000 1", sample_out, rom_bus.rom_sel, rom_bus.rom_addr, busy);
    end
    frame(s, b, d);
    checks++; if (s !== 16'hFFFF) begin errors++; $display("[TB] FAIL fetch_preempt_first: got %h want ffff", s); end
    checks++; if (done_cnt !== d0) begin errors++; $display("[TB] FAIL restart_no_done: got %0d want %0d", done_cnt, d0); end
    do_reset();
  endtask

  task automatic test_reset_mid_fetch();
    logic [15:0] s;
    logic b, d;
    int bad = 0;
    req_dead = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) frame(s, b, d);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (sample_out !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || rom_bus.rom_sel !== 1'b0 || rom_bus.rom_addr !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: sample=%h busy=%b done=%b sel=%b addr=%h want all 0", sample_out, busy, done, rom_bus.rom_sel, rom_bus.rom_addr);
    end
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (busy !== 1'b0) bad++;
    end
    frame(s, b, d);
    if (s !== 16'd0 || b !== 1'b0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL held_req_after_reset: %0d busy observations want 0", bad); end
    req_dead = 1'b0;
    cyc();
    req_dead = 1'b1;
    cyc();
    checks++; if (busy !== 1'b1 || rom_bus.rom_sel !== 1'b1) begin errors++; $display("[TB] FAIL rearm_dead: busy=%b sel=%b want 1 1", busy, rom_bus.rom_sel); end
    do_reset();
  endtask

  // Frame-level model: which effect is playing and the next sample index.
  task automatic test_random();
    logic [15:0] s, es;
    logic b, d, ed;
    bit active = 1'b0, eff = 1'b0;
    int idx = 0, bad = 0, first_it = -1, r, len;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        req_dead = 1'b0; cyc(); req_dead = 1'b1; cyc();
        active = 1'b1; eff = 1'b1; idx = 0;
      end else if (r == 1) begin
        req_jump = 1'b0; cyc(); req_jump = 1'b1; cyc();
        if (!active || !eff) begin active = 1'b1; eff = 1'b0; idx = 0; end
      end else if (r == 2) begin
        mute = ~mute;
      end
      frame(s, b, d);
      ed = 1'b0;
      if (active) begin
        es = mute ? 16'd0 : rom_word(eff, 16'(idx));
        idx++;
        len = eff ? DEAD_LEN : JUMP_LEN;
        if (idx == len) begin active = 1'b0; ed = 1'b1; end
      end else begin
        es = 16'd0;
      end
      if (s !== es || b !== active || d !== ed ||
          (active && (rom_bus.rom_sel !== eff || rom_bus.rom_addr !== 16'(idx)))) begin
        if (bad == 0) first_it = it;
        bad++;
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL random_model: %0d bad frames, first iteration %0d", bad, first_it); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_jump_full();
    test_preempt();
    test_simultaneous();
    test_restart();
    test_mute();
    test_reset_mid_fetch();
    test_random();
    checks++; if (addr_viol !== 0) begin errors++; $display("[TB] FAIL addr_bound: %0d out-of-range addresses want 0", addr_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sfx_scheduler.md
SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 The block SHALL have parameter JUMP_LEN, default 4096, meaning the jump-effect length in samples.
REQ-002 The block SHALL have parameter DEAD_LEN, default 16384, meaning the death-effect length in samples.
REQ-003 The block SHALL have port clk  input  1  as its single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  as its asynchronous, active-high reset.
REQ-005 The block SHALL have port req_jump  input  1  as the jump-sound request, a level from game logic.
REQ-006 The block SHALL have port req_dead  input  1  as the death-sound request, a level from game logic.
REQ-007 The block SHALL have port sample_tick  input  1  as a one-clk pulse per audio frame, already synchronous to clk and spaced at least 3 clks apart.
REQ-008 The block SHALL have port mute  input  1  which forces captured samples to zero.
REQ-009 The block SHALL have port rom_data  input  16  as the sample word from the selected ROM, valid 1 clk after rom_sel/rom_addr.
REQ-010 The block SHALL have port rom_sel  output  1  as the ROM select: 0 = jump ROM, 1 = death ROM.
REQ-011 The block SHALL have port rom_addr  output  16  as the sample address into the selected ROM.
REQ-012 The block SHALL have port sample_out  output  16  as the signed PCM word fed to the I2S serializer.
REQ-013 The block SHALL have port busy  output  1  which is high while an effect is playing.
REQ-014 The block SHALL have port done  output  1  as a one-clk pulse when an effect completes naturally.

Function
REQ-015 The block SHALL detect requests on rising edges of req_jump/req_dead using registered previous values; a held-high level SHALL trigger exactly one playback.
REQ-016 The block SHALL implement FSM states IDLE, PLAY, FETCH; busy SHALL be 1 in PLAY and FETCH, 0 in IDLE.
REQ-017 In IDLE, a dead edge SHALL go to PLAY with rom_sel=1, rom_addr=0; otherwise a jump edge SHALL go to PLAY with rom_sel=0, rom_addr=0.
REQ-018 Simultaneous dead and jump edges SHALL start the death effect; the jump edge SHALL be dropped.
REQ-019 In PLAY or FETCH with rom_sel=0, a dead edge SHALL preempt the effect: next clk state=PLAY, rom_sel=1, rom_addr=0, with no pending FETCH capture.
REQ-020 In PLAY or FETCH, an edge on the currently playing effect SHALL restart it (rom_addr=0, state=PLAY); a jump edge during the death effect SHALL be ignored.
REQ-021 In PLAY, sample_tick SHALL move to FETCH with rom_addr held.
REQ-022 In FETCH, the block SHALL load sample_out with rom_data (0 if mute), then return to PLAY with rom_addr+1.
REQ-023 If the FETCH address equals LEN-1 of the selected effect, the block SHALL capture the sample, go to IDLE, reset rom_addr to 0, and pulse done for that clk.
REQ-024 sample_out SHALL hold its value between captures; in IDLE, sample_tick SHALL clear sample_out to 0, so the last sample plays for one full frame.
REQ-025 A sample_tick arriving in FETCH SHALL be ignored.
REQ-026 rom_addr SHALL never exceed LEN-1 of the selected effect, and no wrap-around SHALL occur.
REQ-027 A preemption or restart SHALL suppress done.

Reset
REQ-028 Reset SHALL force state=IDLE, rom_sel=0, rom_addr=0, sample_out=0, busy=0, done=0, and edge registers=0, at any time including mid-playback.
REQ-029 A request level held high through reset release SHALL NOT trigger playback.

Verification
REQ-030 Jump edge, then 4096 ticks with rom_data=addr -> sample_out steps 0..4095, done pulses once after capture 4095, busy falls; the next tick gives sample_out=0.
REQ-031 Jump playing at addr 100, dead edge -> next clk rom_sel=1, rom_addr=0, no done; the death effect runs 16384 samples.
REQ-032 Death playing, jump edge -> ignored; rom_sel stays 1 and the address sequence is unbroken.
REQ-033 Both requests rise on the same clk in IDLE -> rom_sel=1; the jump effect never plays.
REQ-034 mute=1 during playback -> sample_out=0 while the addresses still advance and done occurs on schedule.
REQ-035 Reset asserted mid-FETCH with req_dead held high -> all outputs 0 immediately; after release there is no playback until req_dead falls and rises again.
